// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling on brg16_tick, mid-bit sampling, LSB first.
// Presents each byte with a one-clock done pulse and a framing-error level.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 brg16_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d,
    output logic                 rx_done_tick,
    output logic                 framing_err,
    output logic                 rx_busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q;
    logic [3:0]             tick_ctr_q;
    logic [BW-1:0]          bit_ctr_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   d_q;
    logic                   done_q;
    logic                   ferr_q;

    // Resetting the synchroniser to idle-high keeps reset from looking like a start edge.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_ctr_q <= '0;
            bit_ctr_q  <= '0;
            shift_q    <= '0;
            d_q        <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q    <= S_START;
                        tick_ctr_q <= '0;
                    end
                end
                S_START: begin
                    if (brg16_tick) begin
                        if (tick_ctr_q == 4'd7) begin
                            tick_ctr_q <= '0;
                            bit_ctr_q  <= '0;
                            state_q    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_ctr_q <= tick_ctr_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (brg16_tick) begin
                        if (tick_ctr_q == 4'd15) begin
                            tick_ctr_q <= '0;
                            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                            if (bit_ctr_q == LAST_BIT) state_q   <= S_STOP;
                            else                       bit_ctr_q <= bit_ctr_q + BW'(1);
                        end else begin
                            tick_ctr_q <= tick_ctr_q + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be caught.
                    if (brg16_tick) begin
                        if (tick_ctr_q == 4'd15) begin
                            tick_ctr_q <= '0;
                            d_q        <= shift_q;
                            ferr_q     <= ~rx_s;
                            done_q     <= 1'b1;
                            state_q    <= rx_s ? S_IDLE : S_BRK;
                        end else begin
                            tick_ctr_q <= tick_ctr_q + 4'd1;
                        end
                    end
                end
                S_BRK: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign d            = d_q;
    assign rx_done_tick = done_q;
    assign framing_err  = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a clock-accurate serial driver pushes expected bytes,
// a monitor pops and compares on every rx_done_tick.
module tb_uart_rx;

    localparam int DIV = 4;            // clocks per brg16 tick
    localparam int BIT_CLK = 16 * DIV; // clocks per bit

    logic       clk = 1'b0;
    logic       reset;
    logic       brg16_tick;
    logic       rx;
    logic [7:0] d;
    logic       rx_done_tick;
    logic       framing_err;
    logic       rx_busy;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_done = 1'b0;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .brg16_tick   (brg16_tick),
        .rx           (rx),
        .d            (d),
        .rx_done_tick (rx_done_tick),
        .framing_err  (framing_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        brg16_tick = 1'b0;
        forever begin
            @(negedge clk);
            brg16_tick = (cnt == DIV - 1);
            cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_tick) begin
            exp_t e;
            chk("done_not_consecutive", 32'(prev_done), 32'd0);
            chk("tick_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("d", 32'(d), 32'(e.d));
                chk("framing_err", 32'(framing_err), 32'(e.fe));
            end
        end
        prev_done = rx_done_tick;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_low(input int n);
        rx = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // jit: interior edges alternate +5/-5 ticks; abort_clk >= 0 pulses reset there and idles the line.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit jit, input int abort_clk);
        int   bnd[10];
        logic lvl[10];
        for (int j = 0; j < 10; j++) begin
            bnd[j] = j * BIT_CLK;
            if (jit && j >= 1) bnd[j] += ((j % 2) != 0 ? 5 : -5) * DIV;
        end
        lvl[0] = 1'b0;
        for (int j = 1; j <= 8; j++) lvl[j] = b[j-1];
        lvl[9] = stop;
        if (abort_clk < 0) sb.push_back('{b, ~stop});
        for (int t = 0; t < 10 * BIT_CLK; t++) begin
            @(negedge clk);
            if (t == abort_clk) begin
                reset = 1'b1;
                rx    = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            for (int j = 0; j < 10; j++) if (t >= bnd[j]) rx = lvl[j];
        end
    endtask

    task automatic drain(input string nm);
        idle(BIT_CLK);
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_done", 32'(rx_done_tick), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        idle(2 * BIT_CLK);

        // Plain frames with idle gaps
        send_frame(8'h00, 1'b1, 1'b0, -1); idle(BIT_CLK);
        send_frame(8'h81, 1'b1, 1'b0, -1); idle(BIT_CLK);
        send_frame(8'hF0, 1'b1, 1'b0, -1); idle(BIT_CLK);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        drain("drain_basic");

        // Short low glitch: rejected at mid start bit
        hold_low(4 * DIV);
        chk("glitch_busy_hi", 32'(rx_busy), 32'd1);
        idle(8 * DIV);
        chk("glitch_busy_lo", 32'(rx_busy), 32'd0);
        chk("glitch_d_held", 32'(d), 32'h55);
        idle(BIT_CLK);

        // Stop bit low followed by a long break, then a good frame
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        hold_low(40 * BIT_CLK);
        chk("brk_busy", 32'(rx_busy), 32'd1);
        chk("brk_ferr", 32'(framing_err), 32'd1);
        idle(2 * BIT_CLK);
        chk("brk_release_busy", 32'(rx_busy), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        drain("drain_break");
        chk("ferr_cleared", 32'(framing_err), 32'd0);

        // Line held low from idle: exactly one 0x00 frame with framing error
        sb.push_back('{8'h00, 1'b1});
        hold_low(30 * BIT_CLK);
        idle(2 * BIT_CLK);
        chk("idle_brk_busy", 32'(rx_busy), 32'd0);
        chk("drain_idle_brk", 32'(sb.size()), 32'd0);

        // Reset late in data bit 4 of 0xAA
        send_frame(8'hAA, 1'b1, 1'b0, 5 * BIT_CLK + 12 * DIV);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_ferr", 32'(framing_err), 32'd0);
        chk("abort_busy", 32'(rx_busy), 32'd0);
        chk("abort_done", 32'(rx_done_tick), 32'd0);
        idle(6 * BIT_CLK);
        send_frame(8'hBB, 1'b1, 1'b0, -1);
        drain("drain_abort");

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hAA, 1'b1, 1'b0, -1);
        drain("drain_b2b");

        // Edge jitter of +/-5 ticks
        send_frame(8'h96, 1'b1, 1'b1, -1);
        drain("drain_jitter");
        chk("final_busy", 32'(rx_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
